keccak_pad_packer: RTL and testbench

KECCAK_PAD_PACKER -- requirements
Module: keccak_pad_packer

---
 rtl/keccak_pkg.sv | 24 ++
 rtl/keccak_pad_packer_if.sv | 23 ++
 rtl/keccak_pad_packer.sv | 145 ++++++++++++++
 tb/tb_keccak_pad_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak constants: lane rates, domain suffix bytes, pad terminator.
// Also holds the padder FSM state type and a little-endian byte placement helper.
package keccak_pkg;

    localparam logic [4:0] RATE_SHAKE128 = 5'd21;
    localparam logic [4:0] RATE_SHAKE256 = 5'd17;
    localparam logic [4:0] RATE_SHA3_256 = 5'd17;
    localparam logic [4:0] RATE_SHA3_512 = 5'd9;

    localparam logic [7:0] DOM_SHAKE = 8'h1F;
    localparam logic [7:0] DOM_SHA3  = 8'h06;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_OUT  = 1'b1
    } pad_state_t;

    // Byte k of a lane lives at bits 8k+7:8k.
    function automatic logic [63:0] place_byte(input logic [7:0] b, input logic [2:0] pos);
        return {56'd0, b} << {pos, 3'b000};
    endfunction

endpackage

// File: rtl/keccak_pad_packer_if.sv
// Byte-stream in / 64-bit lane out handshake bundle for the Keccak padder.
// master = byte producer and sponge side, slave = the padder itself.
interface keccak_pad_packer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_empty;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_ready;

    modport master (
        output in_valid, in_data, in_last, in_empty, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_empty, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/keccak_pad_packer.sv
// Packs a message byte stream into 64-bit lanes with Keccak pad10*1 and domain suffix.
// Lane appears one cycle after its 8th/last byte; input stalls while a lane waits on out_ready.
module keccak_pad_packer
    import keccak_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           rate_words,
    input  logic [7:0]           domain,
    keccak_pad_packer_if.slave   s,
    output logic                 busy
);

    pad_state_t  state;
    logic [63:0] lane_buf;
    logic [2:0]  byte_idx;
    logic [4:0]  lane_idx;
    logic [4:0]  rate_q;
    logic [7:0]  dom_q;
    logic        suffix_pending;
    logic        pad_mode;
    logic [63:0] out_data_q;
    logic        out_valid_q;
    logic        out_last_q;

    logic        accept;
    logic        fire;
    logic        empty_msg;
    logic [4:0]  rate_e;
    logic [7:0]  dom_e;
    logic        suffix_here;
    logic [2:0]  suffix_pos;
    logic [63:0] fill_lane;
    logic        close_fill;
    logic [4:0]  lane_idx_nx;
    logic        pad_close;
    logic [63:0] pad_lane;

    assign s.in_ready  = (state == ST_FILL);
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;

    assign accept    = s.in_valid && (state == ST_FILL);
    assign fire      = out_valid_q && s.out_ready;
    assign empty_msg = s.in_last && s.in_empty;

    always_comb begin
        // The first byte of a message uses the live rate/domain; later bytes the latched copy.
        rate_e      = busy ? rate_q : rate_words;
        dom_e       = busy ? dom_q  : domain;
        suffix_here = s.in_last && (s.in_empty || (byte_idx != 3'd7));
        suffix_pos  = s.in_empty ? byte_idx : byte_idx + 3'd1;

        fill_lane = lane_buf;
        if (!empty_msg) begin
            fill_lane = fill_lane | place_byte(s.in_data, byte_idx);
        end
        if (suffix_here) begin
            fill_lane = fill_lane | place_byte(dom_e, suffix_pos);
        end
        close_fill = suffix_here && (lane_idx == rate_e - 5'd1);
        if (close_fill) begin
            fill_lane[63:56] = fill_lane[63:56] | PAD_END;
        end

        lane_idx_nx = (lane_idx == rate_q - 5'd1) ? 5'd0 : lane_idx + 5'd1;
        pad_close   = (lane_idx_nx == rate_q - 5'd1);
        pad_lane    = 64'd0;
        if (suffix_pending) begin
            pad_lane = pad_lane | place_byte(dom_q, 3'd0);
        end
        if (pad_close) begin
            pad_lane[63:56] = pad_lane[63:56] | PAD_END;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_FILL;
            lane_buf       <= 64'd0;
            byte_idx       <= 3'd0;
            lane_idx       <= 5'd0;
            rate_q         <= 5'd0;
            dom_q          <= 8'd0;
            suffix_pending <= 1'b0;
            pad_mode       <= 1'b0;
            out_data_q     <= 64'd0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (!busy) begin
                            rate_q <= rate_words;
                            dom_q  <= domain;
                        end
                        if ((byte_idx == 3'd7) || s.in_last) begin
                            out_data_q     <= fill_lane;
                            out_valid_q    <= 1'b1;
                            out_last_q     <= close_fill;
                            pad_mode       <= s.in_last;
                            // Last byte landed in byte 7: the suffix rides in the next lane.
                            suffix_pending <= s.in_last && !suffix_here;
                            state          <= ST_OUT;
                        end else begin
                            lane_buf <= fill_lane;
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                ST_OUT: begin
                    if (fire) begin
                        lane_idx <= lane_idx_nx;
                        if (out_last_q) begin
                            state          <= ST_FILL;
                            out_valid_q    <= 1'b0;
                            out_last_q     <= 1'b0;
                            busy           <= 1'b0;
                            lane_buf       <= 64'd0;
                            byte_idx       <= 3'd0;
                            lane_idx       <= 5'd0;
                            pad_mode       <= 1'b0;
                            suffix_pending <= 1'b0;
                        end else if (pad_mode) begin
                            out_data_q     <= pad_lane;
                            out_last_q     <= pad_close;
                            suffix_pending <= 1'b0;
                        end else begin
                            state       <= ST_FILL;
                            out_valid_q <= 1'b0;
                            lane_buf    <= 64'd0;
                            byte_idx    <= 3'd0;
                        end
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_pad_packer.sv
// Randomized bench for keccak_pad_packer against a byte-level pad10*1 reference model.
module tb_keccak_pad_packer;
    import keccak_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rate_words;
    logic [7:0] domain;
    logic       busy;

    always #5 clk = ~clk;

    keccak_pad_packer_if bus();

    keccak_pad_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rate_words (rate_words),
        .domain     (domain),
        .s          (bus),
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  msg_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_at(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    // Reference: message || domain || zeros up to a whole number of blocks, last byte |= 0x80.
    task automatic build_expected(input int rate, input logic [7:0] dom);
        logic [7:0]  p[$];
        logic [63:0] lane;
        p = msg_q;
        p.push_back(dom);
        while ((p.size() % (8 * rate)) != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        exp_q.delete();
        for (int l = 0; l < p.size() / 8; l++) begin
            lane = 64'd0;
            for (int b = 0; b < 8; b++) lane[8*b +: 8] = p[8*l + b];
            exp_q.push_back(lane);
        end
    endtask

    task automatic run_msg(input int rate, input logic [7:0] dom, input bit stall);
        int          n_send;
        int          bi;
        int          k;
        int          cyc;
        int          stall_left;
        bit          hold_chk;
        bit          scramble;
        logic [63:0] held;
        build_expected(rate, dom);
        obs_q.delete();
        n_send     = (msg_q.size() == 0) ? 1 : msg_q.size();
        bi         = 0;
        k          = 0;
        cyc        = 0;
        stall_left = stall ? 5 : 0;
        hold_chk   = 1'b0;
        scramble   = 1'b0;
        held       = 64'd0;
        rate_words = 5'(rate);
        domain     = dom;
        while (k < exp_q.size() && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (scramble) begin
                rate_words = 5'($urandom_range(1, 21));
                domain     = 8'($urandom);
                scramble   = 1'b0;
            end
            if (bi < n_send && $urandom_range(3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = (msg_q.size() == 0) ? 8'($urandom) : msg_q[bi];
                bus.in_last  = (bi == n_send - 1);
                bus.in_empty = (msg_q.size() == 0);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'b0;
                bus.in_empty = 1'b0;
            end
            if (stall_left > 0 && bus.out_valid) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = stall || ($urandom_range(3) != 0);
            end
            #1;
            if (hold_chk) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", bus.out_data, held);
                chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
                chk("hold_busy", 64'(busy), 64'd1);
            end
            hold_chk = bus.out_valid && !bus.out_ready;
            held     = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                bi++;
                if (bi == 1) scramble = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back(bus.out_data);
                chk($sformatf("lane_data[%0d]", k), bus.out_data, exp_q[k]);
                chk($sformatf("lane_last[%0d]", k), 64'(bus.out_last), 64'(k == exp_q.size() - 1));
                k++;
            end
        end
        chk("lane_count", 64'(k), 64'(exp_q.size()));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_empty  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("busy_after", 64'(busy), 64'd0);
        chk("valid_after", 64'(bus.out_valid), 64'd0);
        chk("in_ready_after", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int len;
        int rsel;
        rst_n         = 1'b0;
        rate_words    = RATE_SHA3_256;
        domain        = DOM_SHA3;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.in_last   = 1'b0;
        bus.in_empty  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // SHAKE128 zero-length message.
        msg_q.delete();
        run_msg(21, DOM_SHAKE, 1'b0);
        chk("shake128_empty_l0", obs_at(0), 64'h0000_0000_0000_001F);
        chk("shake128_empty_l20", obs_at(20), 64'h8000_0000_0000_0000);
        chk("shake128_empty_n", 64'(obs_q.size()), 64'd21);

        // SHA3-256 "abc" with a 5-cycle sponge stall.
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(17, DOM_SHA3, 1'b1);
        chk("abc_l0", obs_at(0), 64'h0000_0000_0663_6261);
        chk("abc_l16", obs_at(16), 64'h8000_0000_0000_0000);

        // SHAKE256 135 zero bytes: suffix and terminator share the last byte.
        msg_q.delete();
        for (int i = 0; i < 135; i++) msg_q.push_back(8'h00);
        run_msg(17, DOM_SHAKE, 1'b0);
        chk("shake256_135_top", 64'(obs_at(16) >> 56), 64'h9F);
        chk("shake256_135_n", 64'(obs_q.size()), 64'd17);

        // SHAKE256 136 0xFF bytes: exactly one block of data, one extra pad block.
        msg_q.delete();
        for (int i = 0; i < 136; i++) msg_q.push_back(8'hFF);
        run_msg(17, DOM_SHAKE, 1'b0);
        chk("shake256_136_n", 64'(obs_q.size()), 64'd34);
        chk("shake256_136_l16", obs_at(16), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("shake256_136_l17", obs_at(17), 64'h0000_0000_0000_001F);
        chk("shake256_136_l33", obs_at(33), 64'h8000_0000_0000_0000);

        // Rate 1: suffix pending into a lane that also closes the block.
        msg_q.delete();
        for (int i = 0; i < 8; i++) msg_q.push_back(8'($urandom));
        run_msg(1, DOM_SHA3, 1'b0);

        for (int m = 0; m < 8; m++) begin
            rsel = $urandom_range(3);
            rsel = (rsel == 0) ? 21 : (rsel == 1) ? 17 : (rsel == 2) ? 9 : $urandom_range(1, 21);
            len  = (m == 0) ? 8 * rsel - 1 : (m == 1) ? 8 * rsel + 1 : $urandom_range(0, 200);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            run_msg(rsel, ($urandom_range(1) != 0) ? DOM_SHAKE : DOM_SHA3, 1'b0);
        end

        // Reset after 5 bytes discards the partial message.
        rate_words = RATE_SHA3_256;
        domain     = DOM_SHA3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h30 + i);
            bus.in_last  = 1'b0;
            bus.in_empty = 1'b0;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_lane", 64'(bus.out_valid), 64'd0);
        end
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(17, DOM_SHA3, 1'b0);
        chk("abc2_l0", obs_at(0), 64'h0000_0000_0663_6261);
        chk("abc2_l16", obs_at(16), 64'h8000_0000_0000_0000);
        chk("abc2_n", 64'(obs_q.size()), 64'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
